// File: rtl/edge_detector_bank_if.sv
// Bus bundle for edge_detector_bank: run-time controls, raw inputs and per-channel results.
// Define EDGE_DETECTOR_BANK_COUNT_EN to add i_clear_count / o_edge_count.
interface edge_detector_bank_if #(
  parameter int WIDTH       = 4,
  parameter int COUNT_WIDTH = 8
);

  logic             i_enable;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_in;
  logic [WIDTH-1:0] o_level;
  logic [WIDTH-1:0] o_pulse;
  logic             o_any_pulse;

`ifdef EDGE_DETECTOR_BANK_COUNT_EN
  logic                         i_clear_count;
  logic [WIDTH*COUNT_WIDTH-1:0] o_edge_count;

  modport master (
    output i_enable, i_mode, i_in, i_clear_count,
    input  o_level, o_pulse, o_any_pulse, o_edge_count
  );

  modport slave (
    input  i_enable, i_mode, i_in, i_clear_count,
    output o_level, o_pulse, o_any_pulse, o_edge_count
  );
`else
  modport master (
    output i_enable, i_mode, i_in,
    input  o_level, o_pulse, o_any_pulse
  );

  modport slave (
    input  i_enable, i_mode, i_in,
    output o_level, o_pulse, o_any_pulse
  );
`endif

  if (WIDTH < 1) begin : g_bad_width
    $error("edge_detector_bank_if: WIDTH must be >= 1");
  end
  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("edge_detector_bank_if: COUNT_WIDTH must be >= 1");
  end

endinterface

// File: rtl/edge_detector_bank.sv
// Multi-channel synchroniser, debouncer and run-time selectable edge-pulse generator.
// Optional per-channel saturating edge counters when EDGE_DETECTOR_BANK_COUNT_EN is defined.
module edge_detector_bank #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  edge_detector_bank_if.slave   bus
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("edge_detector_bank: WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("edge_detector_bank: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("edge_detector_bank: DEBOUNCE must be >= 1");
  end
  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("edge_detector_bank: COUNT_WIDTH must be >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync [WIDTH];
  logic [CNT_W-1:0]       r_cnt  [WIDTH];
  logic [WIDTH-1:0]       r_level;
  logic [WIDTH-1:0]       r_pulse;
  logic                   r_any_pulse;

  logic [WIDTH-1:0]       w_sync;
  logic [WIDTH-1:0]       w_accept;
  logic [WIDTH-1:0]       w_pulse_next;
  logic                   w_rise_en;
  logic                   w_fall_en;

  // Decode which edge directions may pulse at this clock edge
  always_comb begin
    w_rise_en = 1'b0;
    w_fall_en = 1'b0;
    if (bus.i_enable) begin
      case (bus.i_mode)
        2'b00: begin
          w_rise_en = 1'b1;
          w_fall_en = 1'b0;
        end
        2'b01: begin
          w_rise_en = 1'b0;
          w_fall_en = 1'b1;
        end
        2'b10: begin
          w_rise_en = 1'b1;
          w_fall_en = 1'b1;
        end
        default: begin
          w_rise_en = 1'b0;
          w_fall_en = 1'b0;
        end
      endcase
    end else begin
      w_rise_en = 1'b0;
      w_fall_en = 1'b0;
    end
  end

  // Per-channel acceptance of a persistent new value and the pulse it would raise
  always_comb begin
    w_sync       = {WIDTH{1'b0}};
    w_accept     = {WIDTH{1'b0}};
    w_pulse_next = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_sync[i]       = r_sync[i][SYNC_STAGES-1];
      w_accept[i]     = (w_sync[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
      w_pulse_next[i] = w_accept[i] &&
                        ((w_sync[i] && w_rise_en) || (!w_sync[i] && w_fall_en));
    end
  end

  // Input synchroniser chains; stage 0 is the metastability-exposed flop
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= {SYNC_STAGES{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.i_in[i]};
      end
    end
  end

  // Debounce counters and accepted level; a run is restarted whenever sync agrees with level
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_level <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] == r_level[i]) begin
          r_cnt[i] <= {CNT_W{1'b0}};
        end else if (w_accept[i]) begin
          r_level[i] <= w_sync[i];
          r_cnt[i]   <= {CNT_W{1'b0}};
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered pulses, aligned with the cycle the level first shows its new value
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pulse     <= {WIDTH{1'b0}};
      r_any_pulse <= 1'b0;
    end else begin
      r_pulse     <= w_pulse_next;
      r_any_pulse <= |w_pulse_next;
    end
  end

  assign bus.o_level     = r_level;
  assign bus.o_pulse     = r_pulse;
  assign bus.o_any_pulse = r_any_pulse;

`ifdef EDGE_DETECTOR_BANK_COUNT_EN
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [COUNT_WIDTH-1:0]       r_count [WIDTH];
  logic [WIDTH*COUNT_WIDTH-1:0] w_edge_count;

  // Saturating edge counters; clear wins over a same-cycle increment
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_count[i] <= {COUNT_WIDTH{1'b0}};
      end
    end else if (bus.i_clear_count) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_count[i] <= {COUNT_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_pulse[i] && (r_count[i] != COUNT_MAX)) begin
          r_count[i] <= r_count[i] + 1'b1;
        end
      end
    end
  end

  // Flatten counters onto the output bus, channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
  always_comb begin
    w_edge_count = {(WIDTH*COUNT_WIDTH){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_edge_count[i*COUNT_WIDTH +: COUNT_WIDTH] = r_count[i];
    end
  end

  assign bus.o_edge_count = w_edge_count;
`else
`endif

endmodule

// File: tb/tb_edge_detector_bank.sv
// Scoreboard bench for edge_detector_bank: a delay-line / sliding-window model predicts
// level, pulse, any_pulse (and edge counts when EDGE_DETECTOR_BANK_COUNT_EN) every cycle.
module tb_edge_detector_bank;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic [W-1:0]    level;
    logic [W-1:0]    pulse;
    logic            any;
    logic [W*CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  edge_detector_bank_if #(.WIDTH(W), .COUNT_WIDTH(CW)) ifc ();

  edge_detector_bank #(
    .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE(DB), .COUNT_WIDTH(CW)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  exp_t        sb_q[$];
  logic [W-1:0] dl[$];
  logic [W-1:0] win[$];
  logic [W-1:0] m_level;
  logic [W-1:0] m_pulse;
  int unsigned  m_cnt[W];

  task automatic model_reset();
    dl.delete();
    for (int k = 0; k < SS; k++) dl.push_back('0);
    win.delete();
    m_level = '0;
    m_pulse = '0;
    for (int k = 0; k < W; k++) m_cnt[k] = 0;
  endtask

  function automatic logic qualifies(input logic en, input logic [1:0] md, input logic rising);
    if (!en) return 1'b0;
    if (md == 2'd2) return 1'b1;
    if (md == 2'd0) return rising;
    if (md == 2'd1) return !rising;
    return 1'b0;
  endfunction

  initial begin
    exp_t         e;
    logic [W-1:0] s;
    logic [W-1:0] newp;
    logic         clr;
    logic         stable;
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
      end else begin
`ifdef EDGE_DETECTOR_BANK_COUNT_EN
        clr = ifc.i_clear_count;
`else
        clr = 1'b0;
`endif
        s = dl.pop_front();
        dl.push_back(ifc.i_in);
        win.push_back(s);
        if (win.size() > DB) void'(win.pop_front());
        for (int i = 0; i < W; i++) begin
          if (clr) m_cnt[i] = 0;
          else if (m_pulse[i] && m_cnt[i] < (2**CW - 1)) m_cnt[i]++;
        end
        newp = '0;
        for (int i = 0; i < W; i++) begin
          stable = (win.size() == DB);
          foreach (win[j]) if (win[j][i] != s[i]) stable = 1'b0;
          if (stable && s[i] != m_level[i]) begin
            m_level[i] = s[i];
            newp[i]    = qualifies(ifc.i_enable, ifc.i_mode, s[i]);
          end
        end
        m_pulse = newp;
      end
      e.level = m_level;
      e.pulse = m_pulse;
      e.any   = |m_pulse;
      for (int i = 0; i < W; i++) e.cnt[i*CW +: CW] = CW'(m_cnt[i]);
      sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (rst) e = '0;
        checks++;
        if (ifc.o_level !== e.level) begin
          errors++;
          $display("FAIL level: got %b expected %b at %0t", ifc.o_level, e.level, $time);
        end
        checks++;
        if (ifc.o_pulse !== e.pulse) begin
          errors++;
          $display("FAIL pulse: got %b expected %b at %0t", ifc.o_pulse, e.pulse, $time);
        end
        checks++;
        if (ifc.o_any_pulse !== e.any) begin
          errors++;
          $display("FAIL any_pulse: got %b expected %b at %0t", ifc.o_any_pulse, e.any, $time);
        end
`ifdef EDGE_DETECTOR_BANK_COUNT_EN
        checks++;
        if (ifc.o_edge_count !== e.cnt) begin
          errors++;
          $display("FAIL edge_count: got %h expected %h at %0t", ifc.o_edge_count, e.cnt, $time);
        end
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_clear(input logic v);
`ifdef EDGE_DETECTOR_BANK_COUNT_EN
    ifc.i_clear_count = v;
`else
    if (v) begin end
`endif
  endtask

  initial begin
    int lat;
    rst          = 1'b1;
    ifc.i_enable = 1'b1;
    ifc.i_mode   = 2'b00;
    ifc.i_in     = '0;
    set_clear(1'b0);
    step(3);
    rst = 1'b0;
    step(4);

    // rising edge on ch0: latency must be SYNC_STAGES + DEBOUNCE edges
    ifc.i_in[0] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (ifc.o_pulse[0] === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != SS + DB) begin
      errors++;
      $display("FAIL latency: got %0d edges expected %0d", lat, SS + DB);
    end
    step(8);

    // glitch shorter than DEBOUNCE, then a real pulse on ch1, both edges
    ifc.i_mode  = 2'b10;
    ifc.i_in[1] = 1'b1; step(3);
    ifc.i_in[1] = 1'b0; step(10);
    ifc.i_in[1] = 1'b1; step(10);
    ifc.i_in[1] = 1'b0; step(10);

    // falling-only on ch2, then pulses suppressed while level tracks
    ifc.i_mode  = 2'b01;
    ifc.i_in[2] = 1'b1; step(10);
    ifc.i_in[2] = 1'b0; step(10);
    ifc.i_in[2] = 1'b1; step(3);
    ifc.i_mode  = 2'b11; step(10);
    ifc.i_mode  = 2'b01;
    ifc.i_in[2] = 1'b0; step(3);
    ifc.i_enable = 1'b0; step(10);
    ifc.i_enable = 1'b1;

    // simultaneous edges on ch0 (1->0) and ch3 (0->1)
    ifc.i_mode  = 2'b10;
    ifc.i_in[0] = 1'b0;
    ifc.i_in[3] = 1'b1; step(10);

    // reset aborts a pending debounce
    ifc.i_in[3] = 1'b0; step(2);
    rst = 1'b1; step(1);
    ifc.i_in[3] = 1'b1; step(1);
    rst = 1'b0; step(12);

    // all inputs high through reset
    ifc.i_mode = 2'b00;
    ifc.i_in   = 4'hF;
    rst = 1'b1; step(3);
    rst = 1'b0; step(12);
    ifc.i_in = 4'h0; step(10);

    // counter saturation and clear-vs-increment priority
    for (int k = 0; k < 5; k++) begin
      ifc.i_in[0] = 1'b1; step(10);
      ifc.i_in[0] = 1'b0; step(10);
    end
    ifc.i_in[0] = 1'b1; step(SS + DB);
    set_clear(1'b1); step(1);
    set_clear(1'b0); step(10);
    ifc.i_in[0] = 1'b0; step(10);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) == 0) ifc.i_in[i] = ~ifc.i_in[i];
      if ($urandom_range(0, 39) == 0) ifc.i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) ifc.i_enable = ~ifc.i_enable;
      set_clear($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    set_clear(1'b0);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detector_bank.md
Name: edge_detector_bank

Overview:
- Multi-channel, parametrised successor to the single-gate "A low AND B high" detector.
- Synchronises WIDTH asynchronous inputs and debounces each channel.
- Emits single-cycle pulses on rising edges, falling edges or both, with the edge selected at run time.
- Sits between raw board inputs (keys, switches, GPIO) and control FSMs in the design.

Parameters:
- WIDTH, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2)
- DEBOUNCE, 4, consecutive cycles a new synchronised value must persist before it is accepted (>=1; 1 = no filtering)
- COUNT_WIDTH, 8, width of each per-channel edge counter (only used with the optional feature)

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = pulses/counting active; 0 = pulses forced low
- mode  input  2  00 rising, 01 falling, 10 both edges, 11 no pulses
- in  input  WIDTH  raw asynchronous inputs
- level  output  WIDTH  debounced, synchronised level per channel
- pulse  output  WIDTH  one-cycle edge pulse per channel
- any_pulse  output  1  OR of pulse, registered in the same cycle as pulse

Behaviour:
- Reset (asynchronous, active-high):
  - Sync chains, debounce counters, level, pulse and any_pulse all clear to 0.
  - Reset asserted mid-operation aborts any pending debounce with no pulse.
- Synchroniser: in[i] passes through SYNC_STAGES registers; sync[i] is the last stage.
- Debounce, per channel, log2-sized counter cnt[i]:
  - sync == level: cnt <= 0.
  - sync != level and cnt == DEBOUNCE-1: level <= sync and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE sampled cycles never changes level and never pulses.
- Pulses:
  - pulse[i] is registered and is 1 for exactly one cycle, the same cycle level[i] first shows its new value.
  - Qualified by mode and enable, both sampled at that edge.
  - Rising edge = level 0->1; falling edge = 1->0.
  - enable=0 or mode=11: pulse=0, while level keeps tracking.
  - mode changes take effect on the next edge; no pulse is produced retroactively.
- Latency: from the first clock edge sampling a stable new in[i] to level/pulse update = SYNC_STAGES + DEBOUNCE edges. Defaults: 6 edges.
- Post-reset: level starts at 0. An input held high through reset produces one rising pulse SYNC_STAGES+DEBOUNCE edges after release if mode is 00 or 10.
- Channels are fully independent; simultaneous edges on several channels give simultaneous pulse bits, and any_pulse = 1.
- Minimum spacing between pulses on one channel is DEBOUNCE cycles.

Optional Feature:
- EDGE_DETECTOR_BANK_COUNT_EN defined:
  - Adds input clear_count (1 bit) and output edge_count (WIDTH*COUNT_WIDTH, channel i at bits [i*COUNT_WIDTH +: COUNT_WIDTH]).
  - Each counter increments on every asserted pulse[i] and saturates at all-ones; it does not wrap.
  - clear_count=1 zeroes all counters at the next edge and takes priority over a simultaneous increment.
  - Reset clears the counters.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Defaults, mode=00, in[0] 0->1 held: pulse[0]=1 for exactly one cycle at edge 6; level[0]=1 from edge 6; any_pulse=1 in that same cycle; other bits 0.
- mode=10, in[1] high for 3 cycles then low (DEBOUNCE=4): no pulse and level[1] stays 0. Then high 10 cycles and low: two pulses, the second 6 edges after the falling input.
- mode=01 with in[2] rising then falling: pulse only on the falling edge. Switch to mode=11 or enable=0 before the next edge: level still toggles, pulse stays 0.
- in[0] and in[3] change together, mode=10: pulse=4'b1001 in one cycle. Assert reset 2 cycles after an input change: all outputs 0, no pulse after release.
- in=4'hF held through reset, mode=00: pulse=4'hF once, 6 edges after reset release.
- With EDGE_DETECTOR_BANK_COUNT_EN, COUNT_WIDTH=2: 5 rising edges on ch0 give edge_count[1:0]=3 (saturated). clear_count together with a pulse gives 0.
